// File: rtl/bf_input_buffer_pkg.sv
// Shared FFT-stage constants and the read-side state encoding for the butterfly input buffer.
package bf_input_buffer_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG_N = 3;
  localparam int MSG_WIDTH = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bf_buffer_ram.sv
// Two-bank sample store: one write port and two registered read ports; bank is the address MSB.
module bf_buffer_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [2**AW];

  // Contents are deliberately not reset; only the read registers carry state.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/bf_input_buffer.sv
// Ping-pong buffer feeding a radix-2 butterfly: fills a bank with N samples, then
// issues N/2 operand sets (x[k], x[k+N/2], W_N^k) on consecutive cycles.
module bf_input_buffer
  import bf_input_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = MSG_WIDTH,
  parameter int N      = FFT_N,
  parameter int LOG_N  = FFT_LOG_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_nd,
  input  logic [MWIDTH-1:0] in_m,
  output logic [LOG_N-2:0]  tw_addr,
  input  logic [WIDTH-1:0]  tw_data,
  output logic [WIDTH-1:0]  xa,
  output logic [WIDTH-1:0]  xb,
  output logic [WIDTH-1:0]  w,
  output logic [MWIDTH-1:0] m_out,
  output logic              x_nd,
  output logic              busy
);

  // in_nd and x_nd are valid-only strobes: a word moves on every cycle its strobe
  // is high, with no ready/backpressure in either direction.

  logic [LOG_N-1:0]  wr_ptr;
  logic              wr_bank;
  logic [1:0]        pend;
  logic [MWIDTH-1:0] meta [2];

  rd_state_e         rd_state;
  logic              rd_bank;
  logic [LOG_N-2:0]  k;

  logic              vld_q1;
  logic [MWIDTH-1:0] m_q1;
  logic [WIDTH-1:0]  ram_a;
  logic [WIDTH-1:0]  ram_b;

  logic              wrap;
  logic [1:0]        pend_eff;

  assign wrap        = in_nd & (&wr_ptr);
  assign pend_eff[0] = pend[0] | (wrap & ~wr_bank);
  assign pend_eff[1] = pend[1] | (wrap & wr_bank);
  assign tw_addr     = k;

  bf_buffer_ram #(
    .WIDTH (WIDTH),
    .AW    (LOG_N + 1)
  ) u_ram (
    .clk     (clk),
    .we      (in_nd),
    .waddr   ({wr_bank, wr_ptr}),
    .wdata   (in_data),
    .raddr_a ({rd_bank, 1'b0, k}),
    .raddr_b ({rd_bank, 1'b1, k}),
    .rdata_a (ram_a),
    .rdata_b (ram_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      meta[0] <= '0;
      meta[1] <= '0;
    end else if (in_nd) begin
      if (wr_ptr == '0) meta[wr_bank] <= in_m;
      wr_ptr <= wr_ptr + 1'b1;
      if (&wr_ptr) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      k        <= '0;
      pend     <= '0;
      vld_q1   <= 1'b0;
      m_q1     <= '0;
      xa       <= '0;
      xb       <= '0;
      w        <= '0;
      m_out    <= '0;
      x_nd     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wrap) pend[wr_bank] <= 1'b1;

      vld_q1 <= (rd_state == RD_READ);
      m_q1   <= (rd_state == RD_READ && k == '0) ? meta[rd_bank] : '0;
      x_nd   <= vld_q1;
      xa     <= ram_a;
      xb     <= ram_b;
      w      <= tw_data;
      m_out  <= m_q1;
      // Holds through the last pair still in the pipeline after the FSM leaves READ.
      busy   <= vld_q1;

      case (rd_state)
        RD_IDLE: begin
          if (pend[rd_bank]) begin
            rd_state      <= RD_READ;
            k             <= '0;
            pend[rd_bank] <= 1'b0;
            busy          <= 1'b1;
          end
        end
        RD_READ: begin
          busy <= 1'b1;
          k    <= k + 1'b1;
          if (&k) begin
            rd_bank <= ~rd_bank;
            // A bank completing on this very edge is taken without a bubble.
            if (pend_eff[~rd_bank]) pend[~rd_bank] <= 1'b0;
            else                    rd_state       <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
